rgb_gray_tx: RTL and testbench

Producer side of the grayscale frame-memory write path. Accepts the camera's packed RGB byte stream (R, G, B per pixel), converts each pixel to an 8-bit luma byte, and presents it to the frame-memory write port with a valid/ready handshake. A 2-entry output FIFO absorbs sink stalls, because the camera stream cannot be back-pressured. Frame length is N*M pixels; `done` signals the controller when the last gray byte has been accepted.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gs_fifo2.sv | 57 +++++
 rtl/rgb_gray_tx.sv | 150 +++++++++++++++
 tb/tb_rgb_gray_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale write path.
//   state_t      - controller FSM states
//   GRAY_W*      - default Q0.8 luma weights (sum to 256)
//   GRAY_ROUND   - half-LSB added before the >>8 so the result rounds to nearest
//   PH_R/G/B     - byte-phase encodings of the packed RGB camera stream
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int GRAY_WR = 77;
    localparam int GRAY_WG = 150;
    localparam int GRAY_WB = 29;

    localparam logic [15:0] GRAY_ROUND = 16'd128;

    localparam logic [1:0] PH_R = 2'd0;
    localparam logic [1:0] PH_G = 2'd1;
    localparam logic [1:0] PH_B = 2'd2;

endpackage

// File: rtl/gs_fifo2.sv
// Two-entry, 8-bit FIFO that buffers gray bytes between the luma datapath
// and the frame-memory write port.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data; taken when not full, or when full
//                and a pop happens on the same edge
//   pop        : read request; ignored when empty
//   full/empty : occupancy flags
//   dout       : head entry, stable until it is popped
module gs_fifo2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] dout
);

    logic [7:0] mem [0:1];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_pop;
    logic       do_push;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= 8'd0;
            mem[1] <= 8'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rgb_gray_tx.sv
// Converts the camera's packed R,G,B byte stream into 8-bit luma bytes and
// hands them to the frame-memory write port through a 2-entry FIFO.
// Handshake: a byte transfers on every edge where gs_valid && sink_ready;
// gs_data is held while gs_valid && !sink_ready. The camera side has no
// back-pressure, so a byte arriving at a full, non-popping FIFO is dropped
// and flagged through the sticky overflow bit.
//   start      : one-cycle pulse, begins a frame of N*M pixels (IDLE only)
//   cam_valid  : cam_data carries a colour byte (order R, G, B)
//   sink_ready : frame memory accepts gs_data this cycle
//   gs_valid   : FIFO non-empty; gs_data is the head byte
//   busy       : frame in progress (CAPTURE or DRAIN)
//   done       : one-cycle pulse after the last gray byte is popped
//   overflow   : a gray byte was dropped in the current frame
//   state_dbg  : current FSM state
module rgb_gray_tx
    import gray_pkg::*;
#(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int WR = GRAY_WR,
    parameter int WG = GRAY_WG,
    parameter int WB = GRAY_WB
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cam_valid,
    input  logic [7:0] cam_data,
    input  logic       sink_ready,
    output logic       gs_valid,
    output logic [7:0] gs_data,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output state_t     state_dbg
);

    localparam int PIXELS = N * M;
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);

    state_t           state;
    state_t           next_state;
    logic [1:0]       phase;
    logic [PIX_W-1:0] pix_cnt;
    logic [7:0]       r_reg;
    logic [7:0]       g_reg;
    logic             overflow_r;

    logic             cam_take;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [15:0]      acc;
    logic [7:0]       gray;

    assign cam_take = (state == CAPTURE) && cam_valid;
    assign push     = cam_take && (phase == PH_B);
    assign pop      = gs_valid && sink_ready;

    // The B byte is used straight from cam_data so the pixel's gray value is
    // pushed on the same edge that samples B. Max is 255*256+128 = 65408.
    assign acc  = 16'(WR) * {8'd0, r_reg}
                + 16'(WG) * {8'd0, g_reg}
                + 16'(WB) * {8'd0, cam_data}
                + GRAY_ROUND;
    assign gray = acc[15:8];

    gs_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (gray),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (gs_data)
    );

    assign gs_valid  = !fifo_empty;
    assign overflow  = overflow_r;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (push && (pix_cnt == LAST_PIX)) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // No pushes happen here, so a pop from a non-full FIFO
                // removes the final entry.
                if (fifo_empty || (pop && !fifo_full)) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= PH_R;
            pix_cnt    <= '0;
            r_reg      <= 8'd0;
            g_reg      <= 8'd0;
            overflow_r <= 1'b0;
        end else if ((state == IDLE) && start) begin
            phase      <= PH_R;
            pix_cnt    <= '0;
            overflow_r <= 1'b0;
        end else if (cam_take) begin
            case (phase)
                PH_R: begin
                    r_reg <= cam_data;
                    phase <= PH_G;
                end
                PH_G: begin
                    g_reg <= cam_data;
                    phase <= PH_B;
                end
                default: begin
                    phase   <= PH_R;
                    // A dropped pixel still counts toward the frame length.
                    pix_cnt <= pix_cnt + PIX_W'(1);
                    if (fifo_full && !pop) overflow_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_gray_tx.sv
module tb_rgb_gray_tx;
    import gray_pkg::*;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] gray;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start, start_1, cam_valid, sink_ready;
    logic [7:0] cam_data;
    logic       gs_valid, busy, done, overflow;
    logic [7:0] gs_data;
    state_t     st0;
    logic       gs_valid_1, busy_1, done_1, overflow_1;
    logic [7:0] gs_data_1;
    state_t     st1;

    rgb_gray_tx #(.N(2), .M(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cam_valid(cam_valid),
        .cam_data(cam_data), .sink_ready(sink_ready), .gs_valid(gs_valid),
        .gs_data(gs_data), .busy(busy), .done(done), .overflow(overflow),
        .state_dbg(st0)
    );

    rgb_gray_tx #(.N(1), .M(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .cam_valid(cam_valid),
        .cam_data(cam_data), .sink_ready(sink_ready), .gs_valid(gs_valid_1),
        .gs_data(gs_data_1), .busy(busy_1), .done(done_1), .overflow(overflow_1),
        .state_dbg(st1)
    );

    // scoreboard
    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    bit         sel = 1'b0;
    bit         toggle_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    vec_t       vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int s;
        s = 77 * r + 150 * g + 29 * b + 128;
        return 8'(s / 256);
    endfunction

    // monitor: every transfer pops one expected byte
    always @(negedge clk) begin
        logic       mv;
        logic [7:0] md;
        logic [7:0] e;
        if (rst_n) begin
            mv = sel ? gs_valid_1 : gs_valid;
            md = sel ? gs_data_1 : gs_data;
            if (mv && sink_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0d expected none at %0t", md, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("gs_data", 32'(md), 32'(e));
                end
            end
            if (!sel) begin
                if (prev_stall && gs_valid) check("stall_stable", 32'(gs_data), 32'(prev_data));
                if (done) begin
                    done_cnt++;
                    check("busy_low_with_done", 32'(busy), 0);
                end
            end
            prev_stall = gs_valid && !sink_ready;
            prev_data  = gs_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cam_byte(input logic [7:0] d);
        cam_valid = 1'b1;
        cam_data  = d;
        if (toggle_en) sink_ready = ~sink_ready;
        tick();
    endtask

    task automatic send_pixel(input vec_t v, input bit keep);
        cam_byte(v.r);
        cam_byte(v.g);
        if (keep) exp_q.push_back(v.gray);
        cam_byte(v.b);
    endtask

    task automatic wait_done(input string name);
        bit found = 1'b0;
        cam_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(found), 1);
        check({name, "_drained"}, 32'(exp_q.size()), 0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 0);
        check({name, "_idle_after"}, 32'(st0), 32'(IDLE));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0]  = '{8'd100, 8'd0,   8'd0,   8'd30};
        vecs[1]  = '{8'd0,   8'd200, 8'd0,   8'd117};
        vecs[2]  = '{8'd0,   8'd0,   8'd255, 8'd29};
        vecs[3]  = '{8'd0,   8'd0,   8'd0,   8'd0};
        vecs[4]  = '{8'd10,  8'd20,  8'd30,  8'd18};
        vecs[5]  = '{8'd128, 8'd64,  8'd32,  8'd80};
        vecs[6]  = '{8'd1,   8'd2,   8'd3,   8'd2};
        vecs[7]  = '{8'd255, 8'd255, 8'd255, 8'd255};
        vecs[8]  = '{8'd255, 8'd0,   8'd0,   8'd77};
        vecs[9]  = '{8'd0,   8'd255, 8'd0,   8'd149};
        vecs[10] = '{8'd0,   8'd0,   8'd0,   8'd0};
        vecs[11] = '{8'd200, 8'd100, 8'd50,  8'd124};

        rst_n = 1'b0; start = 1'b0; start_1 = 1'b0; cam_valid = 1'b0;
        cam_data = 8'd0; sink_ready = 1'b1;
        tick(); tick();
        check("rst_gs_valid", 32'(gs_valid), 0);
        check("rst_gs_data", 32'(gs_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_state", 32'(st0), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // single white pixel on the 1x1 instance
        sel = 1'b1;
        start_1 = 1'b1; tick(); start_1 = 1'b0;
        check("t1_busy", 32'(busy_1), 1);
        exp_q.push_back(8'd255);
        cam_byte(8'd255); cam_byte(8'd255); cam_byte(8'd255);
        cam_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_latency", 32'(gs_valid_1), 1);
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(gs_valid_1), 0);
        check("t1_done", 32'(done_1), 1);
        check("t1_busy_falls", 32'(busy_1), 0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done_1), 0);
        check("t1_drained", 32'(exp_q.size()), 0);
        check("t1_other_idle", 32'(gs_valid), 0);
        tick();
        sel = 1'b0;

        // table frames with sink_ready held high
        for (int f = 0; f < 3; f++) begin
            d0 = done_cnt;
            pulse_start();
            check("busy_after_start", 32'(busy), 1);
            for (int p = 0; p < 4; p++) send_pixel(vecs[4*f+p], 1'b1);
            wait_done("table");
            check("table_one_done", 32'(done_cnt - d0), 1);
            check("table_no_overflow", 32'(overflow), 0);
        end

        // sink stalled for the whole capture: two kept, two dropped
        sink_ready = 1'b0;
        pulse_start();
        for (int p = 0; p < 4; p++) send_pixel(vecs[p], p < 2);
        cam_valid = 1'b0;
        @(negedge clk);
        check("stall_overflow", 32'(overflow), 1);
        check("stall_head", 32'(gs_data), 32'(vecs[0].gray));
        check("stall_busy", 32'(busy), 1);
        tick();
        sink_ready = 1'b1;
        wait_done("stall");
        check("overflow_sticky", 32'(overflow), 1);
        pulse_start();
        check("overflow_cleared_by_start", 32'(overflow), 0);
        for (int p = 0; p < 4; p++) send_pixel(vecs[4+p], 1'b1);
        wait_done("after_stall");

        // sink_ready toggling every cycle, back-to-back camera bytes
        pulse_start();
        toggle_en = 1'b1;
        for (int p = 0; p < 4; p++) send_pixel(vecs[8+p], 1'b1);
        toggle_en = 1'b0;
        sink_ready = 1'b1;
        wait_done("toggle");
        check("toggle_no_overflow", 32'(overflow), 0);

        // reset mid-frame with an undelivered byte in the FIFO
        sink_ready = 1'b0;
        pulse_start();
        cam_byte(8'd9); cam_byte(8'd9); cam_byte(8'd9);
        cam_byte(8'd50); cam_byte(8'd60);
        rst_n = 1'b0;
        cam_valid = 1'b0;
        #1;
        check("mid_rst_gs_valid", 32'(gs_valid), 0);
        check("mid_rst_gs_data", 32'(gs_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        check("mid_rst_state", 32'(st0), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        sink_ready = 1'b1;
        tick();
        pulse_start();
        for (int p = 0; p < 4; p++) send_pixel(vecs[p], 1'b1);
        wait_done("after_reset");

        // stray bytes in IDLE and start pulses during CAPTURE are ignored
        cam_byte(8'd255); cam_byte(8'd255); cam_byte(8'd255);
        cam_valid = 1'b0;
        @(negedge clk);
        check("idle_bytes_ignored", 32'(gs_valid), 0);
        check("idle_state", 32'(st0), 32'(IDLE));
        tick();
        d0 = done_cnt;
        start = 1'b1;
        cam_byte(8'd77);
        start = 1'b0;
        send_pixel(vecs[4], 1'b1);
        cam_valid = 1'b0;
        pulse_start();
        send_pixel(vecs[5], 1'b1);
        cam_byte(vecs[6].r);
        start = 1'b1;
        cam_byte(vecs[6].g);
        start = 1'b0;
        exp_q.push_back(vecs[6].gray);
        cam_byte(vecs[6].b);
        send_pixel(vecs[7], 1'b1);
        wait_done("start_ignored");
        check("start_ignored_one_done", 32'(done_cnt - d0), 1);

        // random frame, expectations from the reference formula
        pulse_start();
        for (int p = 0; p < 4; p++) begin
            vec_t v;
            v.r = 8'($urandom_range(0, 255));
            v.g = 8'($urandom_range(0, 255));
            v.b = 8'($urandom_range(0, 255));
            v.gray = ref_gray(v.r, v.g, v.b);
            send_pixel(v, 1'b1);
        end
        wait_done("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
